// File: rtl/uart_pkg.sv
// Shared helpers for the UART receive FIFO: level width and almost-full test.
// No ports; imported by uart_rx_fifo and uart_fifo_mem.
package uart_pkg;

   // Level counts 0..depth inclusive, so it needs one bit more than a pointer.
   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic logic afull_f(input int unsigned lvl,
                                    input int unsigned thr);
      return lvl >= thr;
   endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DW storage: synchronous write port, asynchronous read port, no reset.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (combinational read).
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side circular byte buffer between UART receiver and consumer.
// Ports: clk, rstn (async, active-low); in_* / out_* valid/ready handshakes;
// level, almost_full, overrun (sticky), overrun_clr.
// Macro UART_RX_FIFO_DROP_EN: never stall the receiver, drop on full instead.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int DEPTH       = 16,
   parameter int AFULL_LEVEL = 12
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [DATA_WIDTH-1:0]     in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [DATA_WIDTH-1:0]     out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [lvl_w(DEPTH)-1:0]   level,
   output logic                      almost_full,
   output logic                      overrun,
   input  logic                      overrun_clr
);

   localparam int LB_DEPTH = $clog2(DEPTH);
   localparam int LW       = lvl_w(DEPTH);

   localparam logic [LB_DEPTH-1:0] PTR_ONE  = LB_DEPTH'(1);
   localparam logic [LW-1:0]       CNT_ONE  = LW'(1);
   localparam logic [LW-1:0]       CNT_FULL = LW'(DEPTH);

   logic [LB_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [LB_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]       cnt_q, cnt_d;

   logic full;
   logic wr_en;
   logic rd_en;

   assign full      = (cnt_q == CNT_FULL);
   assign out_valid = (cnt_q != '0);
   assign rd_en     = out_valid & out_ready;

`ifdef UART_RX_FIFO_DROP_EN
   logic ovr_q, ovr_d;
   logic drop;

   // A read on the same edge frees a slot, so only a read-less full write drops.
   assign in_ready = 1'b1;
   assign wr_en    = in_valid & (~full | rd_en);
   assign drop     = in_valid & full & ~rd_en;

   // Set has priority over a coincident clear.
   always_comb begin
      ovr_d = ovr_q;
      if (drop) begin
         ovr_d = 1'b1;
      end else if (overrun_clr) begin
         ovr_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ovr_q <= 1'b0;
      end else begin
         ovr_q <= ovr_d;
      end
   end

   assign overrun = ovr_q;
`else
   logic unused_clr;

   // Ready comes from registered count only; a read never opens a full slot
   // in the same cycle.
   assign in_ready   = ~full;
   assign wr_en      = in_valid & in_ready;
   assign overrun    = 1'b0;
   assign unused_clr = overrun_clr;
`endif

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      unique case ({wr_en, rd_en})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign level       = cnt_q;
   assign almost_full = afull_f(32'(cnt_q), AFULL_LEVEL);

   uart_fifo_mem #(
      .DW    (DATA_WIDTH),
      .DEPTH (DEPTH),
      .AW    (LB_DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr_q),
      .wdata (in_data),
      .raddr (rd_ptr_q),
      .rdata (out_data)
   );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo with DEPTH=4, AFULL_LEVEL=3.
// Accepted writes are queued; a negedge monitor pops and compares on each read.
module tb_uart_rx_fifo;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rstn;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] level;
   logic       almost_full;
   logic       overrun;
   logic       overrun_clr;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q [$];
   int         mcnt = 0;
   logic       movr = 1'b0;

   uart_rx_fifo #(
      .DATA_WIDTH  (8),
      .DEPTH       (D),
      .AFULL_LEVEL (3)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .level       (level),
      .almost_full (almost_full),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every DUT read must match the oldest accepted word.
   always @(negedge clk) begin
      if (rstn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_empty got %0h want none", out_data);
         end else begin
            chk("rd_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
         end
      end
   end

   // One clock cycle: drive, check status against the model at negedge,
   // record expected writes, then commit the model after the edge.
   task automatic cyc(input logic iv, input logic [7:0] d, input logic ordy);
      logic wr, rd, ovr_n;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      @(negedge clk);
      rd = ordy && (mcnt != 0);
`ifdef UART_RX_FIFO_DROP_EN
      wr = iv && (mcnt != D || rd);
      chk("in_ready", {31'h0, in_ready}, 32'h1);
`else
      wr = iv && (mcnt != D);
      chk("in_ready", {31'h0, in_ready}, {31'h0, mcnt != D});
`endif
      chk("out_valid", {31'h0, out_valid}, {31'h0, mcnt != 0});
      chk("level", {29'h0, level}, mcnt);
      chk("afull", {31'h0, almost_full}, {31'h0, mcnt >= 3});
      chk("overrun", {31'h0, overrun}, {31'h0, movr});
      ovr_n = movr;
`ifdef UART_RX_FIFO_DROP_EN
      if (iv && !wr) ovr_n = 1'b1;
      else if (overrun_clr) ovr_n = 1'b0;
`endif
      if (wr) exp_q.push_back(d);
      @(posedge clk);
      #1;
      mcnt = mcnt + int'(wr) - int'(rd);
      movr = ovr_n;
   endtask

   task automatic peek(input logic [7:0] d);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      chk("peek_valid", {31'h0, out_valid}, 32'h1);
      chk("peek_data", {24'h0, out_data}, {24'h0, d});
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn        = 1'b0;
      in_valid    = 1'b0;
      in_data     = 8'h0;
      out_ready   = 1'b0;
      overrun_clr = 1'b0;
      #12;
      chk("rst_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_ready", {31'h0, in_ready}, 32'h1);
      chk("rst_level", {29'h0, level}, 32'h0);
      chk("rst_afull", {31'h0, almost_full}, 32'h0);
      chk("rst_ovr", {31'h0, overrun}, 32'h0);
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // single word, visible the next cycle
      cyc(1'b1, 8'h55, 1'b0);
      peek(8'h55);
      chk("lvl_one", {29'h0, level}, 32'h1);
      cyc(1'b0, 8'h00, 1'b1);

      // fill to full, then drain in order
      for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b0);
      chk("full_lvl", {29'h0, level}, 32'h4);
      for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);
      chk("drained", {31'h0, out_valid}, 32'h0);

      // streaming at one word per cycle with level held at 1
      cyc(1'b1, 8'h10, 1'b0);
      for (int i = 1; i < 10; i++) begin
         cyc(1'b1, 8'h10 + 8'(i), 1'b1);
         chk("stream_lvl", {29'h0, level}, 32'h1);
      end
      cyc(1'b0, 8'h00, 1'b1);

      // simultaneous read and write while full
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'h20 + 8'(i), 1'b0);
      cyc(1'b1, 8'h30, 1'b1);
`ifdef UART_RX_FIFO_DROP_EN
      chk("full_rw", {29'h0, level}, 32'h4);
`else
      chk("full_rw", {29'h0, level}, 32'h3);
      cyc(1'b1, 8'h30, 1'b0);
`endif
      for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);

`ifdef UART_RX_FIFO_DROP_EN
      // drop on full, sticky overrun, then clear
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0);
      cyc(1'b1, 8'hEE, 1'b0);
      chk("ovr_set", {31'h0, overrun}, 32'h1);
      for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);
      overrun_clr = 1'b1;
      cyc(1'b0, 8'h00, 1'b0);
      overrun_clr = 1'b0;
      chk("ovr_clr", {31'h0, overrun}, 32'h0);
`endif

      // asynchronous reset mid-stream with two words stored
      cyc(1'b1, 8'h41, 1'b0);
      cyc(1'b1, 8'h42, 1'b0);
      chk("pre_rst_lvl", {29'h0, level}, 32'h2);
      in_valid = 1'b0;
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_valid", {31'h0, out_valid}, 32'h0);
      chk("arst_level", {29'h0, level}, 32'h0);
      exp_q.delete();
      mcnt = 0;
      movr = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      cyc(1'b1, 8'h77, 1'b0);
      peek(8'h77);
      cyc(1'b0, 8'h00, 1'b1);

      cyc(1'b0, 8'h00, 1'b0);
      chk("sb_empty", exp_q.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
